// File: rtl/sequenciador_entradas.sv
// Patient-field entry sequencer: synchronised keypad, per-field decimal entry,
// field commit strobes and a bounded wait on the external classifier.
module sequenciador_entradas #(
    parameter int NUM_FIELDS   = 7,
    parameter int CALC_TIMEOUT = 65535
) (
    input  logic        CLOCK_50,
    input  logic        RST_N,
    input  logic [0:11] IO,
    input  logic        CALC_DONE,
    input  logic        RESULT,
    output logic [3:0]  ESTADO,
    output logic [13:0] VALUE,
    output logic [2:0]  DIGITS,
    output logic        FIELD_WE,
    output logic [2:0]  FIELD_ADDR,
    output logic [13:0] FIELD_DATA,
    output logic        FIELD_CLR,
    output logic        CALC_START,
    output logic        RESULT_Q,
    output logic        ERR,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_ENTRY,
        S_COMMIT,
        S_CALC,
        S_SHOW
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'(NUM_FIELDS - 1);
    localparam logic [3:0]  CALC_IDX = 4'(NUM_FIELDS);
    localparam logic [15:0] TO_LAST  = 16'(CALC_TIMEOUT - 1);

    logic [0:11] sync1_q, sync2_q, prev_q, armed_q;
    logic [1:0]  live_q;
    logic [0:11] key_e;
    logic        clr_e, nxt_e;
    logic [3:0]  dig_cnt, dig_val;
    logic        dig_one;
    logic [13:0] value_mac;

    state_t      state_q, state_d;
    logic [3:0]  estado_q, estado_d;
    logic [13:0] value_q, value_d;
    logic [2:0]  digits_q, digits_d;
    logic        we_q, we_d;
    logic [2:0]  addr_q, addr_d;
    logic [13:0] data_q, data_d;
    logic        clr_q, clr_d;
    logic        start_q, start_d;
    logic        res_q, res_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [15:0] cnt_q, cnt_d;
    logic        restart;

    // Key synchroniser and edge detector; a key is armed only once it has
    // been seen low after reset, so a key held through reset stays silent.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            live_q  <= '0;
        end else begin
            sync1_q <= IO;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            live_q  <= {live_q[0], 1'b1};
            armed_q <= armed_q | (~sync2_q & {12{live_q[1]}});
        end
    end

    assign key_e = sync2_q & ~prev_q & armed_q;
    assign clr_e = key_e[11];
    assign nxt_e = key_e[10];

    // Count digit edges this cycle and remember which digit fired.
    always_comb begin
        dig_cnt = '0;
        dig_val = '0;
        for (int i = 0; i < 10; i++) begin
            if (key_e[i]) begin
                dig_cnt = dig_cnt + 4'd1;
                dig_val = 4'(i);
            end
        end
    end

    assign dig_one   = (dig_cnt == 4'd1);
    assign value_mac = value_q * 14'd10 + {10'd0, dig_val};

    // Next-state and next-output logic with CLEAR taking priority everywhere.
    always_comb begin
        state_d  = state_q;
        estado_d = estado_q;
        value_d  = value_q;
        digits_d = digits_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        clr_d    = 1'b0;
        start_d  = 1'b0;
        res_d    = res_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        restart  = 1'b0;
        if (clr_e) begin
            restart = 1'b1;
        end else begin
            unique case (state_q)
                S_ENTRY: begin
                    if (nxt_e) begin
                        state_d = S_COMMIT;
                        we_d    = 1'b1;
                        addr_d  = estado_q[2:0];
                        data_d  = value_q;
                    end else if (dig_one && digits_q < 3'd4) begin
                        value_d  = value_mac;
                        digits_d = digits_q + 3'd1;
                    end
                end
                S_COMMIT: begin
                    value_d  = '0;
                    digits_d = '0;
                    if (estado_q == LAST_IDX) begin
                        state_d  = S_CALC;
                        estado_d = CALC_IDX;
                        start_d  = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        state_d  = S_ENTRY;
                        estado_d = estado_q + 4'd1;
                    end
                end
                S_CALC: begin
                    if (CALC_DONE) begin
                        res_d   = RESULT;
                        err_d   = 1'b0;
                        state_d = S_SHOW;
                    end else if (cnt_q == TO_LAST) begin
                        res_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_SHOW;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_SHOW: begin
                    if (nxt_e) restart = 1'b1;
                end
                default: ;
            endcase
        end
        if (restart) begin
            state_d  = S_ENTRY;
            estado_d = '0;
            value_d  = '0;
            digits_d = '0;
            res_d    = 1'b0;
            err_d    = 1'b0;
            clr_d    = 1'b1;
        end
        busy_d = (state_d == S_CALC);
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_ENTRY;
            estado_q <= '0;
            value_q  <= '0;
            digits_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            clr_q    <= 1'b0;
            start_q  <= 1'b0;
            res_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            estado_q <= estado_d;
            value_q  <= value_d;
            digits_q <= digits_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            clr_q    <= clr_d;
            start_q  <= start_d;
            res_q    <= res_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ESTADO     = estado_q;
    assign VALUE      = value_q;
    assign DIGITS     = digits_q;
    assign FIELD_WE   = we_q;
    assign FIELD_ADDR = addr_q;
    assign FIELD_DATA = data_q;
    assign FIELD_CLR  = clr_q;
    assign CALC_START = start_q;
    assign RESULT_Q   = res_q;
    assign ERR        = err_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_sequenciador_entradas.sv
// Bench for sequenciador_entradas: directed scenarios plus random keying
// checked against a field-level entry model.
module tb_sequenciador_entradas;

    localparam int NF = 7;
    localparam int TO = 20;
    localparam logic [11:0] K_NEXT = 12'h400;
    localparam logic [11:0] K_CLR  = 12'h800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:11] io;
    logic        calc_done, result;
    logic [3:0]  estado;
    logic [13:0] value;
    logic [2:0]  digits;
    logic        fwe;
    logic [2:0]  faddr;
    logic [13:0] fdata;
    logic        fclr, cstart, res_q, err, busy;

    int checks = 0;
    int failures = 0;
    int clr_cnt = 0;
    int start_cnt = 0;
    int exp_clr = 0;
    int exp_start = 0;
    logic [16:0] got_we[$];
    logic [16:0] exp_we[$];
    int m_phase, m_field, m_value, m_digits;

    sequenciador_entradas #(.NUM_FIELDS(NF), .CALC_TIMEOUT(TO)) dut (
        .CLOCK_50(clk), .RST_N(rst_n), .IO(io),
        .CALC_DONE(calc_done), .RESULT(result),
        .ESTADO(estado), .VALUE(value), .DIGITS(digits),
        .FIELD_WE(fwe), .FIELD_ADDR(faddr), .FIELD_DATA(fdata),
        .FIELD_CLR(fclr), .CALC_START(cstart),
        .RESULT_Q(res_q), .ERR(err), .BUSY(busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (fwe) got_we.push_back({faddr, fdata});
        if (fclr) clr_cnt++;
        if (cstart) start_cnt++;
    end

    function automatic logic [11:0] kd(input int d);
        logic [11:0] m;
        m = '0;
        m[d] = 1'b1;
        return m;
    endfunction

    task automatic drive(input logic [11:0] m);
        for (int i = 0; i < 12; i++) io[i] = m[i];
    endtask

    task automatic model_restart();
        m_phase = 0; m_field = 0; m_value = 0; m_digits = 0;
        exp_clr++;
    endtask

    // phase: 0 entry, 2 waiting on classifier, 3 showing result
    task automatic model_key(input logic [11:0] m);
        int n, d;
        n = 0; d = 0;
        for (int i = 0; i < 10; i++)
            if (m[i]) begin n++; d = i; end
        if (m[11] || (m_phase == 3 && m[10])) begin
            model_restart();
        end else if (m_phase == 0) begin
            if (m[10]) begin
                exp_we.push_back({3'(m_field), 14'(m_value)});
                if (m_field == NF - 1) begin
                    m_phase = 2; m_field = NF; exp_start++;
                end else begin
                    m_field++;
                end
                m_value = 0; m_digits = 0;
            end else if (n == 1 && m_digits < 4) begin
                m_value = m_value * 10 + d;
                m_digits++;
            end
        end
    endtask

    task automatic press(input logic [11:0] m);
        @(negedge clk);
        drive(m);
        model_key(m);
        repeat (3) @(negedge clk);
        drive('0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic flush();
        got_we.delete();
        exp_we.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({estado, value, digits, fwe, faddr, fdata, fclr, cstart,
             res_q, err, busy} !== 44'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {estado, value, digits});
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        m_phase = 0; m_field = 0; m_value = 0; m_digits = 0;
    endtask

    task automatic test_entry();
        int vals[3] = '{4, 42, 427};
        int keys[3] = '{4, 2, 7};
        press(K_CLR);
        flush();
        for (int i = 0; i < 3; i++) begin
            press(kd(keys[i]));
            checks++;
            if (value !== 14'(vals[i])) begin
                failures++;
                $display("FAIL entry_value got=%0d exp=%0d", value, vals[i]);
            end
        end
        press(K_NEXT);
        checks++;
        if (got_we.size() != 1 || got_we[0] !== {3'd0, 14'd427}) begin
            failures++;
            $display("FAIL entry_write n=%0d exp=1 addr0 data427", got_we.size());
        end
        checks++;
        if (estado !== 4'd1 || value !== 14'd0 || digits !== 3'd0) begin
            failures++;
            $display("FAIL entry_advance got=%0d/%0d exp=1/0", estado, value);
        end
        flush();
    endtask

    task automatic test_digit_limit();
        press(K_CLR);
        for (int i = 0; i < 4; i++) press(kd(9));
        press(kd(5));
        checks++;
        if (value !== 14'd9999 || digits !== 3'd4) begin
            failures++;
            $display("FAIL digit_limit got=%0d/%0d exp=9999/4", value, digits);
        end
        press(K_CLR);
        press(kd(3));
        press(kd(1) | kd(2));
        checks++;
        if (value !== 14'd3 || digits !== 3'd1) begin
            failures++;
            $display("FAIL multi_digit got=%0d/%0d exp=3/1", value, digits);
        end
    endtask

    task automatic test_hold();
        press(K_CLR);
        @(negedge clk);
        drive(kd(6));
        model_key(kd(6));
        repeat (20) @(negedge clk);
        checks++;
        if (value !== 14'd6 || digits !== 3'd1) begin
            failures++;
            $display("FAIL hold_once got=%0d/%0d exp=6/1", value, digits);
        end
        drive('0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_calc_done();
        press(K_CLR);
        for (int i = 0; i < NF; i++) press(K_NEXT);
        flush();
        checks++;
        if (start_cnt !== exp_start || estado !== 4'(NF) || busy !== 1'b1) begin
            failures++;
            $display("FAIL calc_enter start=%0d exp=%0d estado=%0d busy=%0b",
                     start_cnt, exp_start, estado, busy);
        end
        repeat (3) @(negedge clk);
        calc_done = 1'b1; result = 1'b1;
        @(negedge clk);
        calc_done = 1'b0; result = 1'b0;
        m_phase = 3;
        checks++;
        if (res_q !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL calc_done got=%0b%0b%0b exp=100", res_q, err, busy);
        end
        press(kd(3));
        checks++;
        if (value !== 14'd0 || res_q !== 1'b1 || estado !== 4'(NF)) begin
            failures++;
            $display("FAIL show_hold got=%0d/%0b exp=0/1", value, res_q);
        end
        press(K_CLR);
        checks++;
        if (res_q !== 1'b0 || clr_cnt !== exp_clr || estado !== 4'd0) begin
            failures++;
            $display("FAIL show_clear got=%0b clr=%0d exp=0 clr=%0d",
                     res_q, clr_cnt, exp_clr);
        end
    endtask

    task automatic test_done_at_start();
        int n;
        press(K_CLR);
        for (int i = 0; i < NF - 1; i++) press(K_NEXT);
        @(negedge clk);
        drive(K_NEXT);
        model_key(K_NEXT);
        n = 0;
        while (cstart !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        calc_done = 1'b1; result = 1'b1;
        @(negedge clk);
        calc_done = 1'b0; result = 1'b0;
        drive('0);
        #1;
        m_phase = 3;
        checks++;
        if (n >= 10 || res_q !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL done_at_start n=%0d res=%0b busy=%0b exp=1/0", n, res_q, busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (start_cnt !== exp_start) begin
            failures++;
            $display("FAIL start_once got=%0d exp=%0d", start_cnt, exp_start);
        end
        flush();
    endtask

    task automatic test_timeout();
        int n, w;
        press(K_CLR);
        for (int i = 0; i < NF - 1; i++) press(K_NEXT);
        result = 1'b1;
        @(negedge clk);
        drive(K_NEXT);
        model_key(K_NEXT);
        n = 0;
        while (cstart !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        drive('0);
        w = 0;
        while (err !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        result = 1'b0;
        m_phase = 3;
        checks++;
        if (n >= 10 || w != TO) begin
            failures++;
            $display("FAIL timeout_cycles got=%0d exp=%0d", w, TO);
        end
        checks++;
        if (res_q !== 1'b0 || busy !== 1'b0 || estado !== 4'(NF)) begin
            failures++;
            $display("FAIL timeout_state res=%0b busy=%0b estado=%0d", res_q, busy, estado);
        end
        calc_done = 1'b1; result = 1'b1;
        @(negedge clk);
        calc_done = 1'b0; result = 1'b0;
        checks++;
        if (err !== 1'b1 || res_q !== 1'b0) begin
            failures++;
            $display("FAIL show_ignore_done got=%0b%0b exp=10", err, res_q);
        end
        press(K_NEXT);
        checks++;
        if (estado !== 4'd0 || err !== 1'b0 || clr_cnt !== exp_clr) begin
            failures++;
            $display("FAIL show_restart estado=%0d err=%0b clr=%0d exp clr=%0d",
                     estado, err, clr_cnt, exp_clr);
        end
        flush();
    endtask

    task automatic test_clear_next();
        press(K_CLR);
        for (int i = 0; i < 3; i++) press(K_NEXT);
        flush();
        press(K_CLR | K_NEXT);
        checks++;
        if (got_we.size() != 0 || estado !== 4'd0 || clr_cnt !== exp_clr) begin
            failures++;
            $display("FAIL clear_next we=%0d estado=%0d clr=%0d exp 0/0/%0d",
                     got_we.size(), estado, clr_cnt, exp_clr);
        end
        flush();
    endtask

    task automatic test_clear_calc();
        press(K_CLR);
        for (int i = 0; i < NF; i++) press(K_NEXT);
        @(negedge clk);
        drive(K_CLR);
        @(negedge clk);
        @(negedge clk);
        calc_done = 1'b1; result = 1'b1;
        @(negedge clk);
        calc_done = 1'b0; result = 1'b0;
        model_key(K_CLR);
        #1;
        checks++;
        if (res_q !== 1'b0 || busy !== 1'b0 || estado !== 4'd0 || clr_cnt !== exp_clr) begin
            failures++;
            $display("FAIL clear_calc res=%0b busy=%0b estado=%0d clr=%0d",
                     res_q, busy, estado, clr_cnt);
        end
        drive('0);
        repeat (5) @(negedge clk);
        checks++;
        if (start_cnt !== exp_start || err !== 1'b0) begin
            failures++;
            $display("FAIL clear_calc_start got=%0d exp=%0d", start_cnt, exp_start);
        end
        flush();
    endtask

    task automatic test_async_reset();
        press(K_CLR);
        for (int i = 0; i < NF; i++) press(K_NEXT);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre busy got=%0b exp=1", busy);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({estado, value, digits, fwe, faddr, fdata, fclr, cstart,
             res_q, err, busy} !== 44'd0) begin
            failures++;
            $display("FAIL areset_outputs estado=%0d busy=%0b", estado, busy);
        end
        drive(kd(5));
        calc_done = 1'b1; result = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        calc_done = 1'b0; result = 1'b0;
        m_phase = 0; m_field = 0; m_value = 0; m_digits = 0;
        checks++;
        if (value !== 14'd0 || digits !== 3'd0 || res_q !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_after value=%0d res=%0b busy=%0b exp 0", value, res_q, busy);
        end
        drive('0);
        repeat (3) @(negedge clk);
        press(kd(5));
        checks++;
        if (value !== 14'd5) begin
            failures++;
            $display("FAIL rearm_press got=%0d exp=5", value);
        end
        flush();
    endtask

    task automatic test_random();
        logic [11:0] m;
        logic [16:0] e, g;
        int r, d1, d2;
        press(K_CLR);
        flush();
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 99);
            d1 = $urandom_range(0, 9);
            d2 = (d1 + 1 + $urandom_range(0, 8)) % 10;
            if (r < 5) m = K_CLR;
            else if (r < 22) m = (m_field == NF - 1) ? K_CLR : K_NEXT;
            else if (r < 32) m = kd(d1) | kd(d2);
            else m = kd(d1);
            if (r >= 5 && r < 22 && $urandom_range(0, 1) == 1) m = m | kd(d1);
            press(m);
            checks++;
            if (estado !== 4'(m_field) || value !== 14'(m_value) ||
                digits !== 3'(m_digits)) begin
                failures++;
                $display("FAIL rand_state it=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         it, estado, value, digits, m_field, m_value, m_digits);
            end
            while (exp_we.size() > 0 && got_we.size() > 0) begin
                e = exp_we.pop_front();
                g = got_we.pop_front();
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL rand_write got=%0h exp=%0h", g, e);
                end
            end
            checks++;
            if (exp_we.size() != 0 || got_we.size() != 0 || clr_cnt !== exp_clr) begin
                failures++;
                $display("FAIL rand_count we=%0d/%0d clr=%0d exp clr=%0d",
                         got_we.size(), exp_we.size(), clr_cnt, exp_clr);
            end
            flush();
        end
    endtask

    initial begin
        io = '0;
        calc_done = 1'b0;
        result = 1'b0;
        test_reset();
        test_entry();
        test_digit_limit();
        test_hold();
        test_calc_done();
        test_done_at_start();
        test_timeout();
        test_clear_next();
        test_clear_calc();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
